// File: rtl/uart_pkg.sv
// Shared UART constants.
// Holds the default oversampling ratio, divisor counter width and reset
// divisor used by the baud tick generator and its prescaler. UART_OS_W is
// the width of an oversample index for the default ratio.
package uart_pkg;

  localparam int UART_OVERSAMPLE  = 16;
  localparam int UART_CNT_W       = 16;
  localparam int UART_DEFAULT_DIV = 20;
  localparam int UART_OS_W        = $clog2(UART_OVERSAMPLE);

endpackage

// File: rtl/baud_prescaler.sv
// Loadable clock prescaler for the baud tick generator.
// Holds the divisor register and the down-counter. It raises wrap_o for
// the one enabled clock in which the counter has reached zero. That is the
// edge at which the parent module registers a sample tick.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en_i         count enable; counter holds while low
//   div_value_i  candidate divisor
//   div_load_i   strobe: latch div_value_i (ignored when it is zero)
//   resync_i     strobe: restart the count from the current divisor
//   restart_o    this edge restarts the count (resync or valid load)
//   wrap_o       this edge is an enabled terminal count (no restart)
module baud_prescaler
  import uart_pkg::*;
#(
  parameter int CNT_W       = UART_CNT_W,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_value_i,
  input  logic             div_load_i,
  input  logic             resync_i,
  output logic             restart_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV   = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_COUNT = CNT_W'(DEFAULT_DIV - 1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_vld;

  // A zero divisor would underflow the counter, so such a load is dropped entirely.
  assign load_vld  = div_load_i && (div_value_i != '0);
  assign restart_o = resync_i || load_vld;
  assign wrap_o    = en_i && !restart_o && (cnt_q == '0);

  // A load takes precedence over resync so a simultaneous pair uses the new divisor.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load_vld) begin
      div_d = div_value_i;
      cnt_d = div_value_i - ONE;
    end else if (resync_i) begin
      cnt_d = div_q - ONE;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? (div_q - ONE) : (cnt_q - ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= RST_DIV;
      cnt_q <= RST_COUNT;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud tick generator shared by UART TX and RX.
// The prescaler produces one wrap per divisor period. This module counts
// the wraps modulo OVERSAMPLE. From the count it registers sample_tick every
// wrap, mid_tick in the middle of each bit and bit_tick at the end of each bit.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           count enable; all counters hold while low
//   div_value    new divisor (clocks per sample_tick)
//   div_load     strobe: latch div_value (zero is ignored)
//   resync       strobe: restart prescaler and bit phase
//   sample_tick  one-cycle pulse per divisor period
//   bit_tick     one-cycle pulse every OVERSAMPLE sample ticks
//   mid_tick     one-cycle pulse at mid-bit
//   sample_idx   current oversample index
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CNT_W       = UART_CNT_W,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [CNT_W-1:0]              div_value,
  input  logic                          div_load,
  input  logic                          resync,
  output logic                          sample_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] sample_idx
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);

  if (OVERSAMPLE < 2 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("baud_tick_gen: OVERSAMPLE must be a power of two >= 2");
  end
  if (DEFAULT_DIV < 1 || DEFAULT_DIV > (2 ** CNT_W) - 1) begin : g_bad_div
    $error("baud_tick_gen: DEFAULT_DIV out of range");
  end

  logic            restart;
  logic            wrap;
  logic [OS_W-1:0] os_q, os_d;
  logic            sample_q, sample_d;
  logic            bit_q, bit_d;
  logic            mid_q, mid_d;

  baud_prescaler #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .div_value_i (div_value),
    .div_load_i  (div_load),
    .resync_i    (resync),
    .restart_o   (restart),
    .wrap_o      (wrap)
  );

  // Ticks decode the index value before it advances. The wrap that leaves
  // index OVERSAMPLE/2-1 is the middle of the bit. The wrap that leaves the
  // last index ends the bit.
  always_comb begin
    os_d     = os_q;
    sample_d = 1'b0;
    bit_d    = 1'b0;
    mid_d    = 1'b0;
    if (restart) begin
      os_d = '0;
    end else if (wrap) begin
      sample_d = 1'b1;
      bit_d    = (os_q == OS_LAST);
      mid_d    = (os_q == OS_MID);
      os_d     = (os_q == OS_LAST) ? '0 : (os_q + OS_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_q     <= '0;
      sample_q <= 1'b0;
      bit_q    <= 1'b0;
      mid_q    <= 1'b0;
    end else begin
      os_q     <= os_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      mid_q    <= mid_d;
    end
  end

  assign sample_tick = sample_q;
  assign bit_tick    = bit_q;
  assign mid_tick    = mid_q;
  assign sample_idx  = os_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: the stimulus pushes the expected tick
// schedule, and the monitor pops one entry per observed tick.
module tb_baud_tick_gen;

  localparam int CNT_W = 16;
  localparam int OS    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] div_value;
  logic             div_load;
  logic             resync;
  logic             sample_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic [3:0]       sample_idx;

  baud_tick_gen #(
    .CNT_W       (CNT_W),
    .OVERSAMPLE  (OS),
    .DEFAULT_DIV (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .div_value   (div_value),
    .div_load    (div_load),
    .resync      (resync),
    .sample_tick (sample_tick),
    .bit_tick    (bit_tick),
    .mid_tick    (mid_tick),
    .sample_idx  (sample_idx)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int cyc;
    bit b;
    bit m;
    int idx;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  // Expect n sample ticks: the first is in the cycle after edge first_edge,
  // then one every d edges. The index starts at os_start before the first tick.
  task automatic push_ticks(input int first_edge, input int d, input int os_start, input int n);
    exp_t e;
    int   os;
    for (int k = 0; k < n; k++) begin
      os    = (os_start + k) % OS;
      e.cyc = first_edge + k * d;
      e.b   = (os == OS - 1);
      e.m   = (os == OS / 2 - 1);
      e.idx = (os + 1) % OS;
      q.push_back(e);
    end
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every observed tick must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (sample_tick || bit_tick || mid_tick)) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tick at edge %0d: got s/b/m=%0d%0d%0d, expected none",
                 edge_n, sample_tick, bit_tick, mid_tick);
      end else begin
        e = q.pop_front();
        chk("tick_edge", edge_n, e.cyc);
        chk("tick_sbm", {29'd0, sample_tick, bit_tick, mid_tick}, {29'd0, 1'b1, e.b, e.m});
        chk("tick_idx", int'(sample_idx), e.idx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at edge %0d: got timeout, expected completion", edge_n);
    $fatal(1, "watchdog");
  end

  int r, l, s, m, p, r2;

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    div_value = '0;
    div_load  = 1'b0;
    resync    = 1'b0;

    // Reset state, then release with the default divisor of 20.
    wait_edge(3);
    chk("rst_outputs", {29'd0, sample_tick, bit_tick, mid_tick}, 0);
    chk("rst_idx", int'(sample_idx), 0);
    rst_n = 1'b1;
    r = edge_n;
    push_ticks(r + 20, 20, 0, 33);
    wait_edge(r + 20);
    chk("def_first_sample", int'(sample_tick), 1);
    wait_edge(r + 160);
    chk("def_mid_160", int'(mid_tick), 1);
    chk("def_nobit_160", int'(bit_tick), 0);
    wait_edge(r + 320);
    chk("def_bit_320", int'(bit_tick), 1);
    chk("def_idx_wrap", int'(sample_idx), 0);

    // Load divisor 5 mid-count, then pause enable for 7 edges between ticks.
    wait_edge(r + 664);
    chk("pre_load_idx", int'(sample_idx), 1);
    div_value = 16'd5;
    div_load  = 1'b1;
    @(posedge clk);
    #1;
    div_load = 1'b0;
    l = edge_n;
    chk("load_idx_zero", int'(sample_idx), 0);
    push_ticks(l + 5, 5, 0, 2);
    push_ticks(l + 22, 5, 2, 14);
    push_ticks(l + 92, 5, 0, 9);
    wait_edge(l + 10);
    en = 1'b0;
    wait_edge(l + 17);
    en = 1'b1;

    // Resync at index 9, with a zero-divisor load partway through that must not disturb anything.
    wait_edge(l + 133);
    chk("pre_resync_idx", int'(sample_idx), 9);
    resync = 1'b1;
    @(posedge clk);
    #1;
    resync = 1'b0;
    s = edge_n;
    chk("resync_idx_zero", int'(sample_idx), 0);
    push_ticks(s + 5, 5, 0, 16);
    wait_edge(s + 21);
    div_value = 16'd0;
    div_load  = 1'b1;
    @(posedge clk);
    #1;
    div_load = 1'b0;

    // Divisor 1: a sample tick every cycle.
    wait_edge(s + 81);
    div_value = 16'd1;
    div_load  = 1'b1;
    @(posedge clk);
    #1;
    div_load = 1'b0;
    m = edge_n;
    push_ticks(m + 1, 1, 0, 32);

    // Simultaneous resync and load of 10.
    wait_edge(m + 32);
    div_value = 16'd10;
    div_load  = 1'b1;
    resync    = 1'b1;
    @(posedge clk);
    #1;
    div_load = 1'b0;
    resync   = 1'b0;
    p = edge_n;
    push_ticks(p + 10, 10, 0, 2);

    // Asynchronous reset while a tick is being presented.
    wait_edge(p + 30);
    chk("pre_rst_tick", int'(sample_tick), 1);
    chk("pre_rst_idx", int'(sample_idx), 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {29'd0, sample_tick, bit_tick, mid_tick}, 0);
    chk("async_rst_idx", int'(sample_idx), 0);
    wait_edge(p + 33);
    rst_n = 1'b1;
    r2 = edge_n;
    push_ticks(r2 + 20, 20, 0, 8);
    wait_edge(r2 + 160);
    chk("post_rst_mid", int'(mid_tick), 1);
    wait_edge(r2 + 165);

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
